// File: rtl/glip_uart_credit_ctrl.sv
// glip_uart_credit_ctrl
// Credit scheduler for the UART backend link. It tracks the egress credit the
// remote has granted us and derives can_send from it. It also tracks free space
// in the local ingress FIFO and issues credit grants to the remote through the
// egress credit request handshake.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   tx_transfer   egress accepted one user word (uses one egress credit)
//   can_send      egress credit available (decoded from egr_cnt register)
//   rx_credit     credit value from a received credit message
//   rx_credit_en  rx_credit valid strobe
//   rx_transfer   one word written into the ingress FIFO
//   fifo_pop      one word removed from the ingress FIFO
//   credit        credit value to transmit (registered)
//   credit_en     credit send request (registered)
//   credit_ack    egress finished sending the credit message
//   error         sticky protocol error, cleared only by rst
module glip_uart_credit_ctrl #(
  parameter int FIFO_DEPTH = 256,
  parameter int THRESHOLD  = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_transfer,
  output logic        can_send,
  input  logic [14:0] rx_credit,
  input  logic        rx_credit_en,
  input  logic        rx_transfer,
  input  logic        fifo_pop,
  output logic [14:0] credit,
  output logic        credit_en,
  input  logic        credit_ack,
  output logic        error
);

  localparam logic [15:0] DEPTH16 = 16'(FIFO_DEPTH);
  localparam logic [15:0] THR16   = 16'(THRESHOLD);

  typedef enum logic {IDLE, REQ} state_t;

  state_t      state;
  logic [15:0] egr_cnt;
  logic [15:0] ing_free;
  logic [15:0] ing_out;

  logic [16:0] egr_sum;
  logic [15:0] egr_sat;
  logic [15:0] egr_next;
  logic        egr_err;
  logic [15:0] grant;
  logic [15:0] out_sum;
  logic [15:0] out_next;
  logic        ing_err;
  logic [15:0] free_next;
  logic        req_cond;
  logic [14:0] credit_init;

  assign can_send = (egr_cnt != '0);

  always_comb begin
    egr_sum   = '0;
    egr_sat   = '0;
    egr_next  = '0;
    egr_err   = 1'b0;
    grant     = '0;
    out_sum   = '0;
    out_next  = '0;
    ing_err   = 1'b0;
    free_next = '0;

    // Incoming credit saturates first; the transfer is then taken from the
    // saturated value. A transfer with no credit held is an error and does
    // not decrement.
    egr_sum  = {1'b0, egr_cnt} + (rx_credit_en ? {2'b00, rx_credit} : 17'd0);
    egr_sat  = egr_sum[16] ? 16'hffff : egr_sum[15:0];
    egr_err  = tx_transfer && (egr_cnt == '0);
    egr_next = (tx_transfer && !egr_err) ? egr_sat - 16'd1 : egr_sat;

    // A grant completing this cycle moves credit from ing_free to ing_out;
    // pops and received words in the same cycle apply on top of it, so an
    // rx_transfer is only an overrun if nothing is outstanding even after
    // the grant lands.
    grant     = (state == REQ && credit_ack) ? {1'b0, credit} : '0;
    out_sum   = ing_out + grant;
    ing_err   = rx_transfer && (out_sum == '0);
    out_next  = (rx_transfer && !ing_err) ? out_sum - 16'd1 : out_sum;
    free_next = ing_free + 16'(fifo_pop) - grant;
  end

  assign req_cond    = (ing_free >= THR16) || ((ing_free != '0) && (ing_out == '0));
  assign credit_init = (ing_free > 16'd32767) ? 15'h7fff : ing_free[14:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      egr_cnt   <= '0;
      ing_free  <= DEPTH16;
      ing_out   <= '0;
      credit    <= '0;
      credit_en <= 1'b0;
      error     <= 1'b0;
    end else begin
      egr_cnt  <= egr_next;
      ing_out  <= out_next;
      ing_free <= free_next;
      if (egr_err || ing_err) error <= 1'b1;
      case (state)
        IDLE: begin
          if (req_cond) begin
            credit    <= credit_init;
            credit_en <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          if (credit_ack) begin
            credit_en <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_glip_uart_credit_ctrl.sv
module tb_glip_uart_credit_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        tx_transfer;
  logic        can_send;
  logic [14:0] rx_credit;
  logic        rx_credit_en;
  logic        rx_transfer;
  logic        fifo_pop;
  logic [14:0] credit;
  logic        credit_en;
  logic        credit_ack;
  logic        error;

  int tests  = 0;
  int fails  = 0;
  int occ    = 0;   // model of ingress FIFO occupancy

  always #5 clk = ~clk;

  glip_uart_credit_ctrl #(.FIFO_DEPTH(256), .THRESHOLD(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .tx_transfer  (tx_transfer),
    .can_send     (can_send),
    .rx_credit    (rx_credit),
    .rx_credit_en (rx_credit_en),
    .rx_transfer  (rx_transfer),
    .fifo_pop     (fifo_pop),
    .credit       (credit),
    .credit_en    (credit_en),
    .credit_ack   (credit_ack),
    .error        (error)
  );

  typedef struct {
    logic        tx;
    logic [14:0] rxc;
    logic        rxc_en;
    logic        rxt;
    logic        pop;
    logic        ack;
    logic        e_can_send;
    int          e_credit;
    logic        e_credit_en;
    logic        e_error;
    int          e_free;
    int          e_out;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs are driven 1 time unit after the active edge and sampled by the
  // DUT on the next edge; outputs are observed 1 unit after that edge.
  task automatic step(input logic tx, input logic [14:0] rxc, input logic rxc_en,
                      input logic rxt, input logic pop, input logic ack);
    tx_transfer  = tx;
    rx_credit    = rxc;
    rx_credit_en = rxc_en;
    rx_transfer  = rxt;
    fifo_pop     = pop;
    credit_ack   = ack;
    @(posedge clk);
    #1;
    if (!rst) occ = occ + int'(rxt) - int'(pop);
    chk("invariant", int'(dut.ing_free) + int'(dut.ing_out) + occ, 256);
  endtask

  task automatic idle();
    step(1'b0, 15'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wait_req(input int budget, input int exp_credit);
    int n = 0;
    while (!credit_en && n < budget) begin
      idle();
      n++;
    end
    chk("req_seen", int'(credit_en), 1);
    chk("req_credit", int'(credit), exp_credit);
  endtask

  function automatic vec_t mk(input logic tx, input int rxc, input logic rxc_en,
                              input logic rxt, input logic pop, input logic ack,
                              input logic cs, input int cr, input logic cen,
                              input logic err, input int fr, input int ou);
    vec_t v;
    v.tx = tx; v.rxc = 15'(rxc); v.rxc_en = rxc_en; v.rxt = rxt; v.pop = pop; v.ack = ack;
    v.e_can_send = cs; v.e_credit = cr; v.e_credit_en = cen; v.e_error = err;
    v.e_free = fr; v.e_out = ou;
    return v;
  endfunction

  initial begin
    //           tx rxc en rxt pop ack | cs  credit cen err free out
    vecs[0] = mk(0, 0, 0, 0, 0, 0,       0, 256, 1, 0, 256, 0);   // grant after release
    vecs[1] = mk(0, 0, 0, 0, 0, 1,       0, 256, 0, 0, 0,   256); // ack grant
    vecs[2] = mk(0, 0, 0, 0, 0, 1,       0, 256, 0, 0, 0,   256); // ack in IDLE ignored
    vecs[3] = mk(0, 3, 1, 0, 0, 0,       1, 256, 0, 0, 0,   256); // remote credit 3
    vecs[4] = mk(1, 0, 0, 0, 0, 0,       1, 256, 0, 0, 0,   256);
    vecs[5] = mk(1, 0, 0, 0, 0, 0,       1, 256, 0, 0, 0,   256);
    vecs[6] = mk(1, 0, 0, 0, 0, 0,       0, 256, 0, 0, 0,   256); // last credit used
    vecs[7] = mk(1, 0, 0, 0, 0, 0,       0, 256, 0, 1, 0,   256); // underflow
    vecs[8] = mk(0, 0, 0, 0, 0, 0,       0, 256, 0, 1, 0,   256); // error sticky

    rst = 1'b1;
    tx_transfer = 0; rx_credit = '0; rx_credit_en = 0;
    rx_transfer = 0; fifo_pop = 0; credit_ack = 0;
    repeat (3) idle();
    chk("rst_can_send", int'(can_send), 0);
    chk("rst_credit", int'(credit), 0);
    chk("rst_credit_en", int'(credit_en), 0);
    chk("rst_error", int'(error), 0);
    chk("rst_free", int'(dut.ing_free), 256);
    chk("rst_out", int'(dut.ing_out), 0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      step(vecs[i].tx, vecs[i].rxc, vecs[i].rxc_en, vecs[i].rxt, vecs[i].pop, vecs[i].ack);
      chk($sformatf("v%0d_can_send", i), int'(can_send), int'(vecs[i].e_can_send));
      chk($sformatf("v%0d_credit", i), int'(credit), vecs[i].e_credit);
      chk($sformatf("v%0d_credit_en", i), int'(credit_en), int'(vecs[i].e_credit_en));
      chk($sformatf("v%0d_error", i), int'(error), int'(vecs[i].e_error));
      chk($sformatf("v%0d_free", i), int'(dut.ing_free), vecs[i].e_free);
      chk($sformatf("v%0d_out", i), int'(dut.ing_out), vecs[i].e_out);
    end

    // Reset clears the sticky error, then reset again while a request is pending.
    rst = 1'b1;
    idle();
    chk("rst2_error", int'(error), 0);
    rst = 1'b0;
    idle();
    chk("req_pending", int'(credit_en), 1);
    rst = 1'b1;
    idle();
    chk("abort_credit_en", int'(credit_en), 0);
    chk("abort_error", int'(error), 0);
    rst = 1'b0;
    idle();
    chk("fresh_credit_en", int'(credit_en), 1);
    chk("fresh_credit", int'(credit), 256);
    step(0, 15'd0, 0, 0, 0, 1);
    chk("fresh_ack_out", int'(dut.ing_out), 256);

    // Threshold boundary: leave one word of credit outstanding so only the
    // threshold rule can trigger a request.
    for (int i = 0; i < 255; i++) step(0, 15'd0, 0, 1, 0, 0);
    chk("rx255_out", int'(dut.ing_out), 1);
    chk("rx255_error", int'(error), 0);
    for (int i = 0; i < 63; i++) begin
      step(0, 15'd0, 0, 0, 1, 0);
      idle();
      chk("below_thr_no_req", int'(credit_en), 0);
    end
    step(0, 15'd0, 0, 0, 1, 0);
    wait_req(3, 64);

    // Ack held off while popping: credit must stay put.
    for (int i = 0; i < 20; i++) begin
      step(0, 15'd0, 0, 0, 1, 0);
      chk("hold_credit", int'(credit), 64);
      chk("hold_credit_en", int'(credit_en), 1);
    end
    step(0, 15'd0, 0, 0, 0, 1);
    chk("hold_ack_free", int'(dut.ing_free), 20);
    chk("hold_ack_out", int'(dut.ing_out), 65);
    chk("hold_ack_en", int'(credit_en), 0);
    // Drain outstanding credit; the 20 words popped during the hold follow.
    for (int i = 0; i < 65; i++) step(0, 15'd0, 0, 1, 0, 0);
    wait_req(3, 20);

    // Ack-cycle collision with every counter input active.
    step(0, 15'd2, 1, 0, 0, 0);
    chk("pre_egr", int'(dut.egr_cnt), 2);
    step(1, 15'd5, 1, 1, 1, 1);
    chk("col_egr", int'(dut.egr_cnt), 6);
    chk("col_out", int'(dut.ing_out), 19);
    chk("col_free", int'(dut.ing_free), 1);
    chk("col_credit_en", int'(credit_en), 0);
    chk("col_error", int'(error), 0);
    chk("col_can_send", int'(can_send), 1);
    idle();
    idle();
    chk("post_col_no_req", int'(credit_en), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
